wb_sram_slave: RTL and testbench
================================

WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

Interface
REQ-001 SHALL have parameter TAGSIZE, default 2, width of all tag signals.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit memory words (power of two, >=2).
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before a response (0..15).
REQ-004 SHALL have ports: clk_i  in  1  clock, rising edge; rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: wb_cyc_i  in  1  cycle valid; wb_stb_i  in  1  strobe; wb_we_i  in  1  write enable.
REQ-006 SHALL have ports: wb_adr_i  in  32  byte address, slave-relative (start address already subtracted upstream); wb_sel_i  in  4  byte lane select.
REQ-007 SHALL have ports: wb_dat_i  in  32  write data; wb_tgd_i  in  TAGSIZE  write data tag.
REQ-008 SHALL have ports: wb_dat_o  out  32  read data; wb_tgd_o  out  TAGSIZE  read data tag; wb_ack_o  out  1  ack; wb_err_o  out  1  error; wb_rty_o  out  1  retry.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-010 IDLE: on wb_cyc_i&wb_stb_i, SHALL capture adr, we, sel, dat, tgd into request registers.
REQ-011 Request SHALL be erroneous if wb_adr_i[1:0]!=0 or wb_adr_i[31:2]>=DEPTH; erroneous request: IDLE->RESP with err, no memory access.
REQ-012 Valid request, WAIT_CYCLES=0: IDLE->RESP with memory access in that same edge; else IDLE->WAIT with counter loaded to WAIT_CYCLES-1.
REQ-013 WAIT: counter decrements each cycle; at counter==0 with wb_cyc_i high, memory access performed and WAIT->RESP.
REQ-014 WAIT: wb_cyc_i low at any edge SHALL abort: WAIT->IDLE, no write, no response.
REQ-015 Memory access, write: for each byte b with sel[b]=1, mem[adr[31:2]] byte b <= dat byte b; other bytes unchanged; sel=0000 is a legal no-op write acked normally.
REQ-016 Memory access, read: wb_dat_o <= full 32-bit word mem[adr[31:2]] (sel ignored), wb_tgd_o <= captured tgd.
REQ-017 RESP: exactly one of wb_ack_o/wb_err_o SHALL be high for exactly one cycle, then RESP->IDLE unconditionally.
REQ-018 Latency: strobe sampled at edge k -> response high during cycle after edge k+1+WAIT_CYCLES (err: cycle after edge k).
REQ-019 A strobe still high in the cycle RESP returns to IDLE SHALL start a new transfer (back-to-back, one idle cycle between responses).
REQ-020 wb_ack_o, wb_err_o SHALL be registered outputs, never combinational from inputs.
REQ-021 wb_dat_o, wb_tgd_o SHALL hold last read value until next read; write/err responses SHALL not change them.
REQ-022 wb_rty_o SHALL be constant 0.
REQ-023 Inputs wb_stb_i changes during WAIT/RESP SHALL be ignored (request registers frozen).

Reset
REQ-024 rst_i high SHALL immediately force state IDLE, counter 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, wb_tgd_o=0, request registers 0.
REQ-025 Reset mid-transfer SHALL drop pending access; no write performed, no response after reset release.
REQ-026 Memory contents SHALL NOT be reset; reads of unwritten words are unspecified (bench writes before reading).

Verification
REQ-027 WAIT_CYCLES=1: write adr=0x10, dat=0xDEADBEEF, sel=1111; read adr=0x10 -> ack 2 cycles after strobe edge, wb_dat_o=0xDEADBEEF.
REQ-028 Byte lanes: write 0x11223344 sel=1111, then 0xAABBCCDD sel=0101 same adr -> read returns 0x11BB33DD.
REQ-029 Errors, DEPTH=1024: adr=0x1000 -> err 1 cycle after strobe, no ack; adr=0x2 -> err; memory at 0x0 unchanged.
REQ-030 Abort: WAIT_CYCLES=3 write 0x5 to adr 0x20, drop cyc in WAIT -> no ack/err; later read adr 0x20 returns prior value.
REQ-031 Reset: assert rst_i in WAIT of a write -> outputs 0 asynchronously, no response after release, target word unchanged.
REQ-032 WAIT_CYCLES=0 back-to-back: stb held high for 3 reads -> ack pulses with exactly one low cycle between, data/tags match each address.

Source files
------------

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave fronting a single-port 32-bit SRAM with
// configurable wait states, byte-lane writes and address error detection.
module wb_sram_slave #(
  parameter int unsigned TAGSIZE     = 2,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [TAGSIZE-1:0] wb_tgd_i,
  output logic [31:0]        wb_dat_o,
  output logic [TAGSIZE-1:0] wb_tgd_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      req_idx_q;
  logic               req_we_q;
  logic [3:0]         req_sel_q;
  logic [31:0]        req_dat_q;
  logic [TAGSIZE-1:0] req_tgd_q;

  logic [31:0] mem [DEPTH];

  logic               req_c, bad_c;
  logic               capture_c, access_c, direct_c;
  logic               ack_d, err_d;
  logic [AW-1:0]      acc_idx_c;
  logic               acc_we_c;
  logic [3:0]         acc_sel_c;
  logic [31:0]        acc_dat_c;
  logic [TAGSIZE-1:0] acc_tgd_c;

  assign wb_rty_o = 1'b0;

  assign req_c = wb_cyc_i & wb_stb_i;
  assign bad_c = (wb_adr_i[1:0] != 2'b00) || ({2'b00, wb_adr_i[31:2]} >= 32'(DEPTH));

  // With zero wait states the access happens on the capture edge, so it uses the bus directly.
  assign acc_idx_c = direct_c ? wb_adr_i[AW+1:2] : req_idx_q;
  assign acc_we_c  = direct_c ? wb_we_i          : req_we_q;
  assign acc_sel_c = direct_c ? wb_sel_i         : req_sel_q;
  assign acc_dat_c = direct_c ? wb_dat_i         : req_dat_q;
  assign acc_tgd_c = direct_c ? wb_tgd_i         : req_tgd_q;

  // Next-state and response decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    access_c  = 1'b0;
    direct_c  = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          capture_c = 1'b1;
          if (bad_c) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_d  = RESP;
            access_c = 1'b1;
            direct_c = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = RESP;
          access_c = 1'b1;
        end else begin
          cnt_d = CW'(cnt_q - 1'b1);
        end
      end
      RESP: begin
        // err was already raised on entry; a good access acks on the way out.
        state_d = IDLE;
        ack_d   = !wb_err_o;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
      wb_tgd_o  <= '0;
      req_idx_q <= '0;
      req_we_q  <= 1'b0;
      req_sel_q <= '0;
      req_dat_q <= '0;
      req_tgd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
      if (capture_c) begin
        req_idx_q <= wb_adr_i[AW+1:2];
        req_we_q  <= wb_we_i;
        req_sel_q <= wb_sel_i;
        req_dat_q <= wb_dat_i;
        req_tgd_q <= wb_tgd_i;
      end
      if (access_c && !acc_we_c) begin
        wb_dat_o <= mem[acc_idx_c];
        wb_tgd_o <= acc_tgd_c;
      end
    end
  end

  // Storage is never reset; only selected byte lanes are written.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (access_c && acc_we_c && acc_sel_c[b]) begin
        mem[acc_idx_c][8*b +: 8] <= acc_dat_c[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: three instances (1, 3 and 0 wait states) driven by
// directed scenarios and random transfers, checked against a word-array model.
module tb_wb_sram_slave;

  localparam int unsigned TS    = 2;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned ND    = 3;

  logic clk = 1'b0;
  logic rst;

  logic          cyc   [ND];
  logic          stb   [ND];
  logic          we    [ND];
  logic [31:0]   adr   [ND];
  logic [3:0]    sel   [ND];
  logic [31:0]   dat_i [ND];
  logic [TS-1:0] tgd_i [ND];
  logic [31:0]   dat_o [ND];
  logic [TS-1:0] tgd_o [ND];
  logic          ack   [ND];
  logic          err   [ND];
  logic          rty   [ND];

  logic [31:0]   mdl      [ND][DEPTH];
  bit            wr       [ND][DEPTH];
  logic [31:0]   last_dat [ND];
  logic [TS-1:0] last_tgd [ND];
  logic [31:0]   bb_adr   [3];
  logic [TS-1:0] bb_tgd   [3];

  int npass  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    wb_sram_slave #(
      .TAGSIZE    (TS),
      .DEPTH      (DEPTH),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 3 : 0)
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .wb_cyc_i(cyc[g]),
      .wb_stb_i(stb[g]),
      .wb_we_i (we[g]),
      .wb_adr_i(adr[g]),
      .wb_sel_i(sel[g]),
      .wb_dat_i(dat_i[g]),
      .wb_tgd_i(tgd_i[g]),
      .wb_dat_o(dat_o[g]),
      .wb_tgd_o(tgd_o[g]),
      .wb_ack_o(ack[g]),
      .wb_err_o(err[g]),
      .wb_rty_o(rty[g])
    );
  end

  function automatic int wcs(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] v, input logic [TS-1:0] t);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
    adr[d] = a; sel[d] = s; dat_i[d] = v; tgd_i[d] = t;
  endtask

  task automatic release_bus(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  // One complete transfer starting just after a falling edge; ends just after a falling edge.
  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] v, input logic [TS-1:0] t);
    bit bad;
    int n;
    int idx;
    bad = (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
    idx = bad ? 0 : int'(a[11:2]);
    drive(d, w, a, s, v, t);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack[d] || err[d]) && n < 40);
    release_bus(d);
    chk($sformatf("latency d%0d a=%h", d, a), 32'(n), bad ? 32'd1 : 32'(2 + wcs(d)));
    chk($sformatf("err d%0d a=%h", d, a), 32'(err[d]), 32'(bad));
    chk($sformatf("ack d%0d a=%h", d, a), 32'(ack[d]), 32'(!bad));
    if (!bad && !w) begin
      chk($sformatf("rdata d%0d a=%h", d, a), dat_o[d], mdl[d][idx]);
      chk($sformatf("rtag d%0d a=%h", d, a), 32'(tgd_o[d]), 32'(t));
      last_dat[d] = mdl[d][idx];
      last_tgd[d] = t;
    end else begin
      chk($sformatf("hold_dat d%0d", d), dat_o[d], last_dat[d]);
      chk($sformatf("hold_tgd d%0d", d), 32'(tgd_o[d]), 32'(last_tgd[d]));
    end
    if (!bad && w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[d][idx][8*b +: 8] = v[8*b +: 8];
      if (s == 4'hF) wr[d][idx] = 1'b1;
    end
    @(negedge clk);
    chk($sformatf("one_pulse d%0d", d), {30'd0, ack[d], err[d]}, 32'd0);
  endtask

  task automatic watch_quiet(input int d, input string tag);
    bit seen;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[d] || err[d]) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int n;
    int kind;
    int idx;
    logic [31:0] a;
    logic [3:0]  s;

    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      release_bus(d);
      we[d] = 1'b0; adr[d] = '0; sel[d] = '0; dat_i[d] = '0; tgd_i[d] = '0;
      last_dat[d] = '0; last_tgd[d] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        wr[d][i] = 1'b0;
        mdl[d][i] = '0;
      end
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_ack d%0d", d), 32'(ack[d]), 32'd0);
      chk($sformatf("rst_err d%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("rst_dat d%0d", d), dat_o[d], 32'd0);
      chk($sformatf("rst_tgd d%0d", d), 32'(tgd_o[d]), 32'd0);
      chk($sformatf("rty d%0d", d), 32'(rty[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read with one wait state.
    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 2'd0);
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 2'd1);
    chk("basic_read", dat_o[0], 32'hDEADBEEF);

    // Byte-lane merge.
    txn(0, 1'b1, 32'h40, 4'hF, 32'h11223344, 2'd0);
    txn(0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD, 2'd0);
    txn(0, 1'b0, 32'h40, 4'hF, 32'h0, 2'd2);
    chk("lane_merge", dat_o[0], 32'h11BB33DD);

    // Error responses leave memory and read registers untouched.
    txn(0, 1'b1, 32'h0, 4'hF, 32'h0BADF00D, 2'd0);
    txn(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 2'd3);
    txn(0, 1'b1, 32'h2, 4'hF, 32'hFFFFFFFF, 2'd3);
    txn(0, 1'b0, 32'h1000, 4'hF, 32'h0, 2'd3);
    txn(0, 1'b0, 32'h0, 4'hF, 32'h0, 2'd1);
    chk("err_no_write", dat_o[0], 32'h0BADF00D);
    txn(0, 1'b1, 32'hFFC, 4'hF, 32'h600DCAFE, 2'd0);
    txn(0, 1'b0, 32'hFFC, 4'hF, 32'h0, 2'd2);
    chk("last_word", dat_o[0], 32'h600DCAFE);

    // Abort in the wait phase with three wait states.
    txn(1, 1'b1, 32'h20, 4'hF, 32'h12345678, 2'd1);
    drive(1, 1'b1, 32'h20, 4'hF, 32'h5, 2'd0);
    @(negedge clk);
    @(negedge clk);
    release_bus(1);
    watch_quiet(1, "abort_quiet");
    txn(1, 1'b0, 32'h20, 4'hF, 32'h0, 2'd3);
    chk("abort_no_write", dat_o[1], 32'h12345678);

    // Reset during the wait phase of a write.
    txn(1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 2'd0);
    txn(1, 1'b0, 32'h30, 4'hF, 32'h0, 2'd2);
    drive(1, 1'b1, 32'h30, 4'hF, 32'h0, 2'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_dat", dat_o[1], 32'd0);
    chk("async_rst_tgd", 32'(tgd_o[1]), 32'd0);
    chk("async_rst_resp", {30'd0, ack[1], err[1]}, 32'd0);
    @(negedge clk);
    release_bus(1);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      last_dat[d] = '0;
      last_tgd[d] = '0;
    end
    watch_quiet(1, "rst_quiet");
    txn(1, 1'b0, 32'h30, 4'hF, 32'h0, 2'd1);
    chk("rst_no_write", dat_o[1], 32'hCAFEF00D);

    // Back-to-back reads with zero wait states and strobe held high.
    bb_adr[0] = 32'h100; bb_adr[1] = 32'h104; bb_adr[2] = 32'hFFC;
    for (int i = 0; i < 3; i++) begin
      txn(2, 1'b1, bb_adr[i], 4'hF, $urandom, 2'd0);
      bb_tgd[i] = TS'($urandom);
    end
    drive(2, 1'b0, bb_adr[0], 4'hF, 32'h0, bb_tgd[0]);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ack[2] && n < 20);
      chk($sformatf("b2b_gap %0d", i), 32'(n), 32'd2);
      chk($sformatf("b2b_dat %0d", i), dat_o[2], mdl[2][bb_adr[i][11:2]]);
      chk($sformatf("b2b_tgd %0d", i), 32'(tgd_o[2]), 32'(bb_tgd[i]));
      last_dat[2] = mdl[2][bb_adr[i][11:2]];
      last_tgd[2] = bb_tgd[i];
      if (i < 2) begin
        adr[2]   = bb_adr[i+1];
        tgd_i[2] = bb_tgd[i+1];
      end else begin
        release_bus(2);
      end
    end
    @(negedge clk);
    chk("b2b_end", {30'd0, ack[2], err[2]}, 32'd0);

    // Random traffic on every instance.
    for (int d = 0; d < ND; d++) begin
      for (int t = 0; t < 40; t++) begin
        kind = int'($urandom_range(0, 9));
        idx  = ($urandom_range(0, 7) == 0) ? DEPTH - 1 : int'($urandom_range(0, 31));
        if (kind == 0) begin
          a = ($urandom_range(0, 1) == 0)
              ? (32'(idx) << 2) | 32'($urandom_range(1, 3))
              : (32'(DEPTH) + 32'($urandom_range(0, 4095))) << 2;
          txn(d, 1'($urandom), a, 4'($urandom), $urandom, TS'($urandom));
        end else if (kind <= 4 && wr[d][idx]) begin
          txn(d, 1'b0, 32'(idx) << 2, 4'($urandom), 32'h0, TS'($urandom));
        end else begin
          s = wr[d][idx] ? 4'($urandom) : 4'hF;
          txn(d, 1'b1, 32'(idx) << 2, s, $urandom, TS'($urandom));
        end
      end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
